mux_nto1_pipe: RTL
==================

Name: mux_nto1_pipe

Overview:
- Parametrised N-input, W-bit selector with a registered output stage for the pipelined datapath. Generalises the fixed 3-input combinational selector.
- Adds valid/ready handshake per input, stall/flush control and an invalid-select error flag.
- Adds an optional round-robin arbitration mode for shared-resource writeback.
- Sits between pipeline stages, e.g. forwarding select or the EX/MEM result select.

Parameters:
- W, 32, data width per input.
- NIN, 3, number of inputs (2..16).
- SW, $clog2(NIN), select width (derived; do not override).
- MODE, 0, 0 = explicit select via sel; 1 = round-robin arbitration over in_valid.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NIN*W  packed inputs; input i occupies bits [i*W +: W].
- in_valid  input  NIN  per-input valid.
- in_ready  output  NIN  per-input accept, combinational.
- sel  input  SW  explicit select (MODE 0 only; ignored in MODE 1).
- stall  input  1  hold output register and arbitration state.
- flush  input  1  invalidate output register.
- out_data  output  W  registered selected data.
- out_valid  output  1  registered valid.
- out_sel  output  SW  registered index of the selected input.
- sel_err  output  1  registered one-cycle pulse: sel >= NIN seen on a load cycle (MODE 0).

Behaviour:
- Reset (async assert, sync release): out_data=0, out_valid=0, out_sel=0, sel_err=0, rr_ptr=0.
- Latency: 1 cycle from an input accept to out_valid/out_data.
- load = !stall && !flush. Flush has priority over stall; flush+stall together gives out_valid=0 next cycle.
- Flush: out_valid<=0 and sel_err<=0; out_data/out_sel hold; rr_ptr holds; in_ready = all 0.
- Stall without flush: all registers hold; in_ready = all 0.
- MODE 0, load cycle:
  - If sel < NIN: grant=sel; out_data<=in_data[sel]; out_valid<=in_valid[sel]; out_sel<=sel; sel_err<=0.
  - If sel >= NIN: out_data<=0, out_valid<=0, out_sel<=0, sel_err<=1. This matches the legacy default-zero rule.
  - in_ready[i] = load && (i == sel), whether or not in_valid[sel] is high.
- MODE 1, load cycle:
  - grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... and wrapping modulo NIN.
  - If any input is valid: out_data<=in_data[grant], out_valid<=1, out_sel<=grant, rr_ptr<=(grant+1) mod NIN.
  - No valid input: out_valid<=0; out_data/out_sel hold; rr_ptr holds.
  - in_ready[i] = load && any_valid && (i == grant); exactly one bit set or none.
  - sel_err is always 0.
- Wrap-around: grant=NIN-1 sets rr_ptr to 0.
- Non-power-of-two NIN: rr_ptr never takes a value >= NIN.
- sel_err clears to 0 on the next load cycle and holds during stall.
- Reset asserted mid-stall or mid-flush: all registers clear immediately.

Decomposition:
- Shared package pipe_pkg holds the MODE_SEL=0 and MODE_RR=1 constants, plus a clog2 helper if the toolchain lacks $clog2.
- Sub-module rr_pick: combinational rotating priority encoder.
  - Inputs: valid vector, rr_ptr.
  - Outputs: grant index, any_valid.
  - Instantiated only when MODE=1.
- The data-select path, output register and control stay in the top level.

Test Plan:
1. MODE0, NIN=3, W=32, in_data={C=0x33,B=0x22,A=0x11}, all valid, sel=1 -> next cycle out_data=0x22, out_valid=1, out_sel=1, in_ready=3'b010 during the load cycle.
2. MODE0, NIN=3, sel=3 -> next cycle out_data=0, out_valid=0, sel_err=1; with sel=0 the following cycle, sel_err=0 and out_data=0x11.
3. MODE0, load 0x22, then stall=1 for 3 cycles while sel=0 -> out_data stays 0x22, in_ready=0; stall+flush together -> out_valid=0 next cycle.
4. MODE1, NIN=4, in_valid=4'b1111 held 5 cycles, no stall -> out_sel sequence 0,1,2,3,0; rr_ptr wraps to 1 after the fifth grant.
5. MODE1, NIN=3, rr_ptr=2, in_valid=3'b001 -> grant=0 (wrap), rr_ptr<=1; then in_valid=0 -> out_valid=0 and rr_ptr stays 1.
6. Assert rst_n=0 asynchronously mid-cycle with out_valid=1, rr_ptr=2 -> outputs and rr_ptr are 0 before the next clk edge.

Source files
------------

// File: rtl/mux_nto1_pipe_pkg.sv
// Shared constants for the pipelined N-to-1 selector.
// MODE_SEL picks by explicit index; MODE_RR arbitrates round-robin over valid inputs.
package mux_nto1_pipe_pkg;
  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;
endpackage

// File: rtl/mux_nto1_pipe_if.sv
// Handshake/datapath bundle for mux_nto1_pipe: packed inputs, select, stall/flush, registered outputs.
// The master drives inputs and control; the slave (the selector) drives in_ready and the output stage.
interface mux_nto1_pipe_if #(
  parameter int W   = 32,
  parameter int NIN = 3,
  parameter int SW  = $clog2(NIN)
);
  logic [NIN*W-1:0] in_data;
  logic [NIN-1:0]   in_valid;
  logic [NIN-1:0]   in_ready;
  logic [SW-1:0]    sel;
  logic             stall;
  logic             flush;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic [SW-1:0]    out_sel;
  logic             sel_err;

  modport master (
    output in_data, in_valid, sel, stall, flush,
    input  in_ready, out_data, out_valid, out_sel, sel_err
  );

  modport slave (
    input  in_data, in_valid, sel, stall, flush,
    output in_ready, out_data, out_valid, out_sel, sel_err
  );
endinterface

// File: rtl/mux_nto1_pipe_rr_pick.sv
// Combinational rotating priority encoder: first valid input at or after rr_ptr, wrapping mod NIN.
// Zero latency; rr_ptr is assumed to be < NIN.
module rr_pick #(
  parameter int NIN = 3,
  parameter int SW  = $clog2(NIN)
) (
  input  logic [NIN-1:0] valid,
  input  logic [SW-1:0]  rr_ptr,
  output logic [SW-1:0]  grant,
  output logic           any_valid
);
  int idx;

  always_comb begin
    grant     = '0;
    any_valid = |valid;
    idx       = 0;
    // Scan farthest-first so the candidate closest to rr_ptr is the last to overwrite grant.
    for (int k = NIN - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NIN) idx = idx - NIN;
      if (valid[idx]) grant = SW'(idx);
    end
  end
endmodule

// File: rtl/mux_nto1_pipe.sv
// N-input W-bit selector with registered output (1-cycle latency), explicit-select or round-robin mode.
// Stall holds all state and drops in_ready; flush (priority over stall) clears out_valid/sel_err only.
module mux_nto1_pipe
  import mux_nto1_pipe_pkg::*;
#(
  parameter int W    = 32,
  parameter int NIN  = 3,
  parameter int SW   = $clog2(NIN),
  parameter int MODE = MODE_SEL
) (
  input logic            clk,
  input logic            rst_n,
  mux_nto1_pipe_if.slave bus
);
  logic           load;
  logic           take;
  logic           rdy_en;
  logic [SW-1:0]  grant;
  logic [W-1:0]   pick_data;
  logic           pick_vld;
  logic [NIN-1:0] ready;

  assign load = !bus.stall && !bus.flush;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SW-1:0] rr_ptr;
      logic [SW-1:0] rr_grant;
      logic          rr_any;

      rr_pick #(.NIN(NIN), .SW(SW)) u_pick (
        .valid    (bus.in_valid),
        .rr_ptr   (rr_ptr),
        .grant    (rr_grant),
        .any_valid(rr_any)
      );

      // Explicit wrap keeps the pointer inside 0..NIN-1 for non-power-of-two NIN.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rr_ptr <= '0;
        end else if (load && rr_any) begin
          rr_ptr <= (rr_grant == SW'(NIN - 1)) ? '0 : rr_grant + 1'b1;
        end
      end

      assign grant  = rr_grant;
      assign take   = rr_any;
      assign rdy_en = rr_any;
    end else begin : g_sel
      assign grant  = bus.sel;
      assign take   = 32'(bus.sel) < NIN;
      assign rdy_en = 1'b1;
    end
  endgenerate

  always_comb begin
    pick_data = '0;
    pick_vld  = 1'b0;
    for (int i = 0; i < NIN; i++) begin
      if (grant == SW'(i)) begin
        pick_data = bus.in_data[i*W +: W];
        pick_vld  = bus.in_valid[i];
      end
    end
  end

  // A MODE_SEL out-of-range select matches no bit, so nothing is accepted.
  always_comb begin
    ready = '0;
    for (int i = 0; i < NIN; i++) begin
      ready[i] = load && rdy_en && (grant == SW'(i));
    end
  end

  assign bus.in_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sel   <= '0;
      bus.sel_err   <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
      bus.sel_err   <= 1'b0;
    end else if (!bus.stall) begin
      if (MODE == MODE_RR) begin
        bus.out_valid <= take;
        bus.sel_err   <= 1'b0;
        if (take) begin
          bus.out_data <= pick_data;
          bus.out_sel  <= grant;
        end
      end else if (take) begin
        bus.out_data  <= pick_data;
        bus.out_valid <= pick_vld;
        bus.out_sel   <= grant;
        bus.sel_err   <= 1'b0;
      end else begin
        bus.out_data  <= '0;
        bus.out_valid <= 1'b0;
        bus.out_sel   <= '0;
        bus.sel_err   <= 1'b1;
      end
    end
  end
endmodule
